gray_ptr_level: RTL and testbench

GRAY_PTR_LEVEL -- requirements
Module: gray_ptr_level

---
 rtl/gray_ptr_pkg.sv | 21 ++
 rtl/gray2bin.sv | 13 +
 rtl/gray_ptr_level.sv | 84 ++++++++
 tb/tb_gray_ptr_level.sv | 136 +++++++++++++
 4 files changed

// File: rtl/gray_ptr_pkg.sv
// gray_ptr_pkg: Gray/binary conversion helpers and constants shared by pointer blocks.
package gray_ptr_pkg;

   localparam int unsigned GRAY_MAX_WIDTH = 32;
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs decode correctly since leading zeros contribute nothing.
   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
      logic [GRAY_MAX_WIDTH-1:0] b;
      b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
      for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder, each bit is the XOR of all gray bits at or above it.
module gray2bin #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[WIDTH-1:i];
   end

endmodule

// File: rtl/gray_ptr_level.sv
// gray_ptr_level: up/down Gray pointer with wrap pulse and optional fill level against a peer.
// Define GRAY_PTR_LEVEL_EN to build the peer decode and level register; otherwise level is 0.
module gray_ptr_level
   import gray_ptr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SAT   = 0
) (
   input  logic             clk_counter,
   input  logic             reset_counter_n,
   input  logic             clear,
   input  logic             ce,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] peer_gray,
   output logic [WIDTH-1:0] binary_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap,
   output logic [WIDTH-1:0] level
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0]          count_q, count_d, gray_q, gray_d;
   logic [GRAY_MAX_WIDTH-1:0] gray_full;
   logic                      wrap_q, wrap_d, step, at_edge;

   always_comb begin
      step      = ce & ~clear & ~load;
      at_edge   = (dir == DIR_UP) ? (count_q == '1) : (count_q == '0);
      count_d   = clear ? '0
                : load  ? load_value
                : !ce   ? count_q
                : (SAT != 0 && at_edge) ? count_q
                : (dir == DIR_UP) ? count_q + ONE : count_q - ONE;
      wrap_d    = (SAT == 0) && step && at_edge;
      gray_full = bin2gray(GRAY_MAX_WIDTH'(count_d));
      gray_d    = gray_full[WIDTH-1:0];
   end

   // Gray is registered from the next count so it never glitches relative to binary_out.
   always_ff @(posedge clk_counter or negedge reset_counter_n) begin
      if (!reset_counter_n) begin
         count_q <= '0;
         gray_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         gray_q  <= gray_d;
         wrap_q  <= wrap_d;
      end
   end

   assign binary_out = count_q;
   assign gray_out   = gray_q;
   assign wrap       = wrap_q;

`ifdef GRAY_PTR_LEVEL_EN
   logic [WIDTH-1:0] peer_bin, level_q, level_d;

   gray2bin #(.WIDTH(WIDTH)) u_peer (
      .gray_i (peer_gray),
      .bin_o  (peer_bin)
   );

   assign level_d = count_d - peer_bin;

   always_ff @(posedge clk_counter or negedge reset_counter_n) begin
      if (!reset_counter_n)
         level_q <= '0;
      else
         level_q <= level_d;
   end

   assign level = level_q;
`else
   logic unused_peer;

   assign unused_peer = ^peer_gray;
   assign level       = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_level.sv
// tb_gray_ptr_level: directed checks of wrap and saturating WIDTH=4 pointers sharing one stimulus.
module tb_gray_ptr_level;

   logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0, ce = 1'b0, dir = 1'b0, load = 1'b0;
   logic [3:0] load_value = '0, peer_gray = '0;
   logic [3:0] bw, gw, lw, bs, gs, ls, prev;
   logic       ww, ws;
   int         errors = 0, checks = 0;
   logic [3:0] gt [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                           4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
`ifdef GRAY_PTR_LEVEL_EN
   localparam logic [3:0] LVL_3_12 = 4'd7;
`else
   localparam logic [3:0] LVL_3_12 = 4'd0;
`endif

   always #5 clk = ~clk;

   gray_ptr_level #(.WIDTH(4), .SAT(0)) u_wrap (
      .clk_counter(clk), .reset_counter_n(rst_n), .clear(clear), .ce(ce), .dir(dir),
      .load(load), .load_value(load_value), .peer_gray(peer_gray),
      .binary_out(bw), .gray_out(gw), .wrap(ww), .level(lw));

   gray_ptr_level #(.WIDTH(4), .SAT(1)) u_sat (
      .clk_counter(clk), .reset_counter_n(rst_n), .clear(clear), .ce(ce), .dir(dir),
      .load(load), .load_value(load_value), .peer_gray(peer_gray),
      .binary_out(bs), .gray_out(gs), .wrap(ws), .level(ls));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic l, input logic e, input logic d, input logic [3:0] v);
      clear = c; load = l; ce = e; dir = d; load_value = v;
   endtask

   initial begin
      #12;
      chk("rst_bin", {bw, bs}, 0);
      chk("rst_gray", {gw, gs}, 0);
      chk("rst_wrap", {ww, ws}, 0);
      chk("rst_level", {lw, ls}, 0);
      rst_n = 1'b1;
      drive(0, 0, 1, 1, 0);
      for (int i = 0; i < 16; i++) begin
         prev = gw;
         tick;
         chk("up_bin", bw, (i + 1) % 16);
         chk("up_gray", gw, gt[(i + 1) % 16]);
         chk("up_wrap", ww, (i == 15) ? 1 : 0);
         chk("up_hamming", $countones(gw ^ prev), 1);
         chk("sat_up_bin", bs, (i < 15) ? i + 1 : 15);
         chk("sat_up_wrap", ws, 0);
      end
      drive(0, 1, 0, 0, 0); tick;
      chk("ld0_bin", bw, 0);
      chk("ld0_wrap", ww, 0);
      drive(0, 0, 1, 0, 0); tick;
      chk("dn_wrap_bin", bw, 15);
      chk("dn_wrap_gray", gw, 8);
      chk("dn_wrap", ww, 1);
      dir = 1'b1; tick;
      chk("tog_up_bin", bw, 0);
      chk("tog_up_wrap", ww, 1);
      dir = 1'b0; tick;
      chk("tog_dn_bin", bw, 15);
      dir = 1'b1; tick;
      chk("tog_up2_bin", bw, 0);
      drive(0, 0, 1, 0, 0); tick;
      drive(0, 0, 1, 1, 0); tick;
      chk("tog_hold_bin", bw, 0);
      chk("tog_hold_wrap", ww, 1);
      drive(0, 1, 0, 0, 14); tick;
      chk("sat_ld14", bs, 14);
      drive(0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("sat_hi_bin", bs, 15);
         chk("sat_hi_gray", gs, 8);
         chk("sat_hi_wrap", ws, 0);
      end
      drive(0, 1, 0, 0, 1); tick;
      chk("sat_ld1", bs, 1);
      drive(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("sat_lo_bin", bs, 0);
         chk("sat_lo_wrap", ws, 0);
      end
      drive(0, 1, 1, 1, 9); tick;
      chk("ld_pri_bin", bw, 9);
      chk("ld_pri_gray", gw, 13);
      chk("ld_pri_wrap", ww, 0);
      drive(1, 1, 1, 1, 9); tick;
      chk("clr_pri_bin", bw, 0);
      chk("clr_pri_gray", gw, 0);
      drive(0, 1, 0, 0, 15); tick;
      chk("ld15_wrap", ww, 0);
      drive(1, 0, 1, 1, 0); tick;
      chk("clr_max_bin", bw, 0);
      chk("clr_max_wrap", ww, 0);
      drive(0, 1, 0, 0, 3); tick;
      drive(0, 0, 0, 0, 0); peer_gray = 4'b1010; tick;
      chk("level_3_12", lw, LVL_3_12);
      chk("level_hold_bin", bw, 3);
      peer_gray = 4'b0010; tick;
      chk("level_3_3", lw, 0);
      drive(0, 1, 0, 0, 5); tick;
      drive(0, 0, 1, 1, 0); tick;
      chk("pre_rst_bin", bw, 6);
      #2 rst_n = 1'b0;
      #1;
      chk("async_bin", bw, 0);
      chk("async_gray", gw, 0);
      chk("async_wrap", ww, 0);
      chk("async_level", lw, 0);
      #2 rst_n = 1'b1;
      tick;
      chk("resume1_bin", bw, 1);
      tick;
      chk("resume2_bin", bw, 2);
      chk("resume2_gray", gw, 3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
